// File: rtl/masked_serial_adder.sv
// rtl/masked_serial_adder.sv - bit-serial d-share Boolean-masked ripple-carry adder

// masked_and_hpc2 - HPC2-style masked AND with one register stage of partial products
module masked_and_hpc2 #(
    parameter int d = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [d-1:0]           a,
    input  logic [d-1:0]           b,
    input  logic [d*(d-1)/2-1:0]   r,
    output logic [d-1:0]           c
);

    // Each cross term a_i*(b_j^r_ij) and ~a_i*r_ij gets its own flop so the
    // output XOR tree only ever combines registered, individually masked terms.
    logic [d-1:0][d-1:0] t_a;
    logic [d-1:0][d-1:0] t_n;

    // r_ij is shared by the (i,j) and (j,i) terms so it cancels on recombination.
    function automatic int pair_idx(input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * d - (lo * (lo + 1)) / 2 + (hi - lo - 1);
    endfunction

    // Register all partial products of the current operand shares.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_a <= '0;
            t_n <= '0;
        end else begin
            for (int i = 0; i < d; i++) begin
                for (int j = 0; j < d; j++) begin
                    if (i == j) begin
                        t_a[i][j] <= a[i] & b[i];
                        t_n[i][j] <= 1'b0;
                    end else begin
                        t_a[i][j] <= a[i] & (b[j] ^ r[pair_idx(i, j)]);
                        t_n[i][j] <= ~a[i] & r[pair_idx(i, j)];
                    end
                end
            end
        end
    end

    // Compress each output share from its own row of registered terms.
    always_comb begin
        c = '0;
        for (int i = 0; i < d; i++) begin
            c[i] = (^t_a[i]) ^ (^t_n[i]);
        end
    end

endmodule

// masked_serial_adder - one masked full-adder step every AND/ACC cycle pair
module masked_serial_adder #(
    parameter int d     = 2,
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [d*WIDTH-1:0]   a_in,
    input  logic [d*WIDTH-1:0]   b_in,
    input  logic [d*(d-1)-1:0]   rnd,
    output logic [d*WIDTH-1:0]   sum_out,
    output logic [d-1:0]         cout_out,
    output logic                 busy,
    output logic                 done
);

    localparam int HALF = d * (d - 1) / 2;
    localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_AND, S_ACC, S_FIN} state_t;

    state_t state;
    state_t state_next;

    // Share j of bit i lives at [j][i], matching the flat j*WIDTH+i port layout.
    logic [d-1:0][WIDTH-1:0] a_reg;
    logic [d-1:0][WIDTH-1:0] b_reg;
    logic [d-1:0][WIDTH-1:0] sum_reg;
    logic [d-1:0][WIDTH-1:0] sum_final;
    logic [d-1:0]            carry;
    logic [d-1:0]            carry_next;
    logic [CW-1:0]           cnt;
    logic                    last_bit;

    logic [d-1:0] a_bit;
    logic [d-1:0] b_bit;
    logic [d-1:0] ab_bit;
    logic [d-1:0] sum_bit;
    logic [d-1:0] and_ab;
    logic [d-1:0] and_cx;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Select the shares of the current bit and form the share-wise sum bit.
    always_comb begin
        a_bit     = '0;
        b_bit     = '0;
        sum_final = sum_reg;
        for (int j = 0; j < d; j++) begin
            a_bit[j] = a_reg[j][cnt];
            b_bit[j] = b_reg[j][cnt];
        end
        ab_bit  = a_bit ^ b_bit;
        sum_bit = ab_bit ^ carry;
        for (int j = 0; j < d; j++) begin
            sum_final[j][cnt] = sum_bit[j];
        end
    end

    masked_and_hpc2 #(.d(d)) u_and_ab (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a_bit),
        .b     (b_bit),
        .r     (rnd[HALF-1:0]),
        .c     (and_ab)
    );

    masked_and_hpc2 #(.d(d)) u_and_cx (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (carry),
        .b     (ab_bit),
        .r     (rnd[2*HALF-1:HALF]),
        .c     (and_cx)
    );

    // Carry update uses only XORs of gadget outputs, never recombined shares.
    assign carry_next = and_ab ^ and_cx;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs; done is visible during the FIN cycle.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_AND;
                end
            end
            S_AND: begin
                busy       = 1'b1;
                state_next = S_ACC;
            end
            S_ACC: begin
                busy       = 1'b1;
                state_next = last_bit ? S_FIN : S_AND;
            end
            S_FIN: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand latch, per-bit accumulate, and result publish on the last ACC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            carry    <= '0;
            cnt      <= '0;
            sum_out  <= '0;
            cout_out <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg   <= a_in;
                        b_reg   <= b_in;
                        sum_reg <= '0;
                        carry   <= '0;
                        cnt     <= '0;
                    end
                end
                S_ACC: begin
                    sum_reg <= sum_final;
                    carry   <= carry_next;
                    if (last_bit) begin
                        sum_out  <= sum_final;
                        cout_out <= carry_next;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_masked_serial_adder.sv
// tb/tb_masked_serial_adder.sv - scoreboard bench for masked_serial_adder
module tb_masked_serial_adder;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             start;
    logic [2*W-1:0]   a_in, b_in, sum_out;
    logic [1:0]       rnd, cout_out;
    logic             busy, done;

    logic             start3;
    logic [3*W-1:0]   a3, b3, sum3;
    logic [5:0]       rnd3;
    logic [2:0]       cout3;
    logic             busy3, done3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W:0] q_val[$];
    int         q_cyc[$];
    logic [W:0] q3_val[$];
    int         q3_cyc[$];

    masked_serial_adder #(.d(2), .WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .rnd(rnd), .sum_out(sum_out), .cout_out(cout_out), .busy(busy), .done(done)
    );

    masked_serial_adder #(.d(3), .WIDTH(W)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a_in(a3), .b_in(b3),
        .rnd(rnd3), .sum_out(sum3), .cout_out(cout3), .busy(busy3), .done(done3)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rnd  = 2'($urandom);
        rnd3 = 6'($urandom);
    end

    function automatic logic [3*W-1:0] mask_val(input logic [W-1:0] v, input int n);
        logic [3*W-1:0] r;
        logic [W-1:0]   acc;
        logic [W-1:0]   m;
        r   = '0;
        acc = v;
        for (int j = 1; j < n; j++) begin
            m = W'($urandom);
            r[j*W +: W] = m;
            acc = acc ^ m;
        end
        r[W-1:0] = acc;
        return r;
    endfunction

    function automatic logic [W-1:0] recomb(input logic [3*W-1:0] v, input int n);
        logic [W-1:0] acc;
        acc = '0;
        for (int j = 0; j < n; j++) acc = acc ^ v[j*W +: W];
        return acc;
    endfunction

    // Monitor for the d=2 instance.
    always @(negedge clk) begin
        logic [W:0] exp_v, got_v;
        int         exp_c;
        if (done) begin
            checks++;
            if (q_val.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done d2: done at cycle %0d, none required", cyc);
            end else begin
                exp_v = q_val.pop_front();
                exp_c = q_cyc.pop_front();
                got_v = {^cout_out, recomb({{W{1'b0}}, sum_out}, 2)};
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL result d2: got %h, required %h", got_v, exp_v);
                end
                checks++;
                if (cyc != exp_c) begin
                    errors++;
                    $display("FAIL latency d2: done at cycle %0d, required %0d", cyc, exp_c);
                end
            end
        end
    end

    // Monitor for the d=3 instance.
    always @(negedge clk) begin
        logic [W:0] exp_v, got_v;
        int         exp_c;
        if (done3) begin
            checks++;
            if (q3_val.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done d3: done at cycle %0d, none required", cyc);
            end else begin
                exp_v = q3_val.pop_front();
                exp_c = q3_cyc.pop_front();
                got_v = {^cout3, recomb(sum3, 3)};
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL result d3: got %h, required %h", got_v, exp_v);
                end
                checks++;
                if (cyc != exp_c) begin
                    errors++;
                    $display("FAIL latency d3: done at cycle %0d, required %0d", cyc, exp_c);
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W:0] exp_v, input bit chk);
        logic [3*W-1:0] t;
        t    = mask_val(a, 2);
        a_in = t[2*W-1:0];
        t    = mask_val(b, 2);
        b_in = t[2*W-1:0];
        start = 1'b1;
        if (chk) begin
            q_val.push_back(exp_v);
            q_cyc.push_back(cyc + 2*W + 1);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue3(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] exp_v);
        a3 = mask_val(a, 3);
        b3 = mask_val(b, 3);
        start3 = 1'b1;
        q3_val.push_back(exp_v);
        q3_cyc.push_back(cyc + 2*W + 1);
        @(negedge clk);
        start3 = 1'b0;
    endtask

    task automatic wait_done(input bit third);
        int n;
        n = 0;
        while (!(third ? done3 : done) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(third ? done3 : done)) begin
            errors++;
            $display("FAIL timeout: no done within %0d cycles, required one", n);
        end
        @(negedge clk);
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst_n  = 1'b0;
        start  = 1'b0;
        start3 = 1'b0;
        a_in = '0; b_in = '0; a3 = '0; b3 = '0;
        rnd = '0; rnd3 = '0;
        repeat (3) @(negedge clk);

        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_done", done, 1'b0);
        check_bit("reset_sum_zero", (sum_out == '0), 1'b1);
        check_bit("reset_cout_zero", (cout_out == '0), 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        issue(16'h1234, 16'h4321, 17'h05555, 1'b1);
        check_bit("busy_after_start", busy, 1'b1);
        wait_done(1'b0);

        for (int k = 0; k < 100; k++) begin
            issue(16'hFFFF, 16'h0001, 17'h10000, 1'b1);
            wait_done(1'b0);
        end

        issue(16'hFFFF, 16'hFFFF, 17'h1FFFE, 1'b1);
        wait_done(1'b0);

        issue3(16'hFFFF, 16'hFFFF, 17'h1FFFE);
        wait_done(1'b1);
        issue3(16'h1234, 16'h4321, 17'h05555);
        wait_done(1'b1);
        issue3(16'hFFFF, 16'h0001, 17'h10000);
        wait_done(1'b1);

        // Busy protection: a second start ten cycles in must be ignored.
        issue(16'd5, 16'd7, 17'd12, 1'b1);
        repeat (9) @(negedge clk);
        issue(16'd1, 16'd1, 17'd0, 1'b0);
        wait_done(1'b0);
        repeat (40) @(negedge clk);

        // Reset mid-operation: no done, outputs cleared.
        issue(16'd9, 16'd9, 17'd0, 1'b0);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_bit("midreset_busy", busy, 1'b0);
        check_bit("midreset_done", done, 1'b0);
        check_bit("midreset_sum_zero", (sum_out == '0), 1'b1);
        check_bit("midreset_cout_zero", (cout_out == '0), 1'b1);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(16'd3, 16'd4, 17'd7, 1'b1);
        wait_done(1'b0);

        for (int k = 0; k < 200; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            issue(ra, rb, {1'b0, ra} + {1'b0, rb}, 1'b1);
            wait_done(1'b0);
        end

        repeat (4) @(negedge clk);
        checks++;
        if (q_val.size() != 0 || q3_val.size() != 0) begin
            errors++;
            $display("FAIL pending_results: got %0d outstanding, required 0",
                     q_val.size() + q3_val.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
